// File: rtl/audio_delta_sigma_dac_if.sv
// audio_delta_sigma_dac_if: valid/ready stream carrying one stereo PCM sample pair per transfer
interface audio_delta_sigma_dac_if #(parameter int DATA_WIDTH = 16);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data_l;
    logic [DATA_WIDTH-1:0] s_data_r;
    modport master (output s_valid, s_data_l, s_data_r, input s_ready);
    modport slave (input s_valid, s_data_l, s_data_r, output s_ready);
endinterface

// File: rtl/audio_delta_sigma_dac.sv
// audio_delta_sigma_dac: FIFO-buffered stereo first-order delta-sigma DAC, one pair released per sample tick.
// Define DAC_DITHER_EN to add +/-1 LSB LFSR dither (clamped) to each modulator input.
module audio_delta_sigma_dac #(
    parameter int DATA_WIDTH = 16,
    parameter int SAMPLE_DIV = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    audio_delta_sigma_dac_if.slave        s,
    output logic                          audio_l,
    output logic                          audio_r,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int W  = DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SAMPLE_DIV);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW:0]    level_q, level_d;
    logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [2*W-1:0] mem_q [FIFO_DEPTH];
    logic [2*W-1:0] mem_d [FIFO_DEPTH];
    logic           ready_q, ready_d;
    logic [W-1:0]   cur_l_q, cur_l_d, cur_r_q, cur_r_d;
    logic [W-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic           audio_l_q, audio_l_d, audio_r_q, audio_r_d;
    logic           tick, push, pop;
    logic [W-1:0]   u_l, u_r;
    logic [W:0]     sum_l, sum_r;

`ifdef DAC_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    function automatic logic [W-1:0] dither(input logic [W-1:0] u, input logic up, input logic dn);
        return (up && !dn && !(&u)) ? u + W'(1) : (dn && !up && |u) ? u - W'(1) : u;
    endfunction
`endif

    always_comb begin
        tick = cnt_q == CW'(SAMPLE_DIV - 1);
        push = s.s_valid && ready_q;
        pop = tick && level_q != '0;
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        wr_d = push ? wr_q + AW'(1) : wr_q;
        rd_d = pop ? rd_q + AW'(1) : rd_q;
        level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
        // ready tracks the post-edge level, so a pop cannot reopen a full FIFO in the same cycle
        ready_d = level_d < (AW+1)'(FIFO_DEPTH);
        mem_d = mem_q;
        mem_d[wr_q] = push ? {s.s_data_l, s.s_data_r} : mem_q[wr_q];
        {cur_l_d, cur_r_d} = pop ? mem_q[rd_q] : {cur_l_q, cur_r_q};
        u_l = {~cur_l_q[W-1], cur_l_q[W-2:0]};
        u_r = {~cur_r_q[W-1], cur_r_q[W-2:0]};
`ifdef DAC_DITHER_EN
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        u_l = dither(u_l, lfsr_q[0], lfsr_q[1]);
        u_r = dither(u_r, lfsr_q[2], lfsr_q[3]);
`endif
        sum_l = {1'b0, acc_l_q} + {1'b0, u_l};
        sum_r = {1'b0, acc_r_q} + {1'b0, u_r};
        acc_l_d = sum_l[W-1:0];
        acc_r_d = sum_r[W-1:0];
        audio_l_d = sum_l[W];
        audio_r_d = sum_r[W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            level_q <= '0;
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            ready_q <= 1'b0;
            cur_l_q <= '0;
            cur_r_q <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
            audio_l_q <= 1'b0;
            audio_r_q <= 1'b0;
`ifdef DAC_DITHER_EN
            lfsr_q <= 16'hACE1;
`endif
        end else begin
            cnt_q <= cnt_d;
            level_q <= level_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            mem_q <= mem_d;
            ready_q <= ready_d;
            cur_l_q <= cur_l_d;
            cur_r_q <= cur_r_d;
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            audio_l_q <= audio_l_d;
            audio_r_q <= audio_r_d;
`ifdef DAC_DITHER_EN
            lfsr_q <= lfsr_d;
`endif
        end
    end

    assign s.s_ready = ready_q;
    assign audio_l = audio_l_q;
    assign audio_r = audio_r_q;
    assign underrun = tick && level_q == '0;
    assign fifo_level = level_q;
endmodule

// File: tb/tb_audio_delta_sigma_dac.sv
// tb_audio_delta_sigma_dac: scoreboard bench; pushed pairs queue expected per-period ones counts checked after each tick.
module tb_audio_delta_sigma_dac;
    localparam int W = 16, DIV = 256, DEPTH = 4;
    typedef struct { logic [15:0] l; logic [15:0] r; } pair_t;

    logic clk = 1'b0, reset = 1'b0;
    logic audio_l, audio_r, underrun;
    logic [2:0] fifo_level;
    int checks = 0, errors = 0, cyc = 0;
    pair_t sb[$];
    logic [15:0] bl [5] = '{16'h4000, 16'h0000, 16'hC000, 16'h8000, 16'h6000};
    logic [15:0] br [5] = '{16'hA000, 16'h2000, 16'hE000, 16'h7F00, 16'h1000};

    audio_delta_sigma_dac_if #(.DATA_WIDTH(W)) bus ();

    audio_delta_sigma_dac #(.DATA_WIDTH(W), .SAMPLE_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .s(bus),
        .audio_l(audio_l), .audio_r(audio_r), .underrun(underrun), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;

    // ones produced by n accumulations of a held sample, for any starting accumulator value
    function automatic int ones_lo(input logic [15:0] smp, input int n);
        longint t = longint'(n) * longint'(smp ^ 16'h8000);
        return int'(t / 65536);
    endfunction

    function automatic int ones_hi(input logic [15:0] smp, input int n);
        longint t = longint'(n) * longint'(smp ^ 16'h8000);
        return int'((t + 65535) / 65536);
    endfunction

    task automatic do_reset();
        bus.s_valid = 1'b0;
        reset = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        int t = 0;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data_l = l;
        bus.s_data_r = r;
        while (bus.s_ready !== 1'b1 && t < 600) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_timeout s_ready=%b want 1", bus.s_ready);
        end else sb.push_back('{l, r});
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_tick();
        while (cyc % DIV != DIV - 1) @(negedge clk);
    endtask

    task automatic measure(input int n, output int ol, output int orr, output int ou);
        ol = 0;
        orr = 0;
        ou = 0;
        repeat (n) begin
            @(negedge clk);
            ol += int'(audio_l);
            orr += int'(audio_r);
            ou += int'(underrun);
        end
    endtask

    task automatic pop_expected(output pair_t e);
        if (sb.size() > 0) e = sb.pop_front();
        else begin
            e = '{16'h0000, 16'h0000};
            checks++;
            errors++;
            $display("FAIL scoreboard_empty size=0 want >0");
        end
    endtask

    task automatic test_reset();
        bus.s_valid = 1'b0;
        bus.s_data_l = '0;
        bus.s_data_r = '0;
        #2 reset = 1'b1;
        #1;
        checks++; if (audio_l !== 1'b0) begin errors++; $display("FAIL reset_audio_l got %b want 0", audio_l); end
        checks++; if (audio_r !== 1'b0) begin errors++; $display("FAIL reset_audio_r got %b want 0", audio_r); end
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", bus.s_ready); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
    endtask

    task automatic test_midscale();
        logic e;
        do_reset();
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b want 0", bus.s_ready); end
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            e = (cyc % 2 == 0);
            if (i == 0) begin
                checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge got %b want 1", bus.s_ready); end
            end
            if (i < 8) begin
                checks++; if (audio_l !== e) begin errors++; $display("FAIL midscale_l cyc=%0d got %b want %b", cyc, audio_l, e); end
                checks++; if (audio_r !== e) begin errors++; $display("FAIL midscale_r cyc=%0d got %b want %b", cyc, audio_r, e); end
            end
            e = (cyc % DIV == DIV - 1);
            checks++; if (underrun !== e) begin errors++; $display("FAIL idle_underrun cyc=%0d got %b want %b", cyc, underrun, e); end
        end
    endtask

    task automatic test_density();
        pair_t e;
        int l1, r1, u1, l2, r2, u2;
        do_reset();
        push_pair(16'h4000, 16'hC000);
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL density_level got %0d want 1", fifo_level); end
        wait_tick();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL density_tick_underrun got %b want 0", underrun); end
        pop_expected(e);
        @(negedge clk);
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL density_pop_level got %0d want 0", fifo_level); end
        measure(254, l1, r1, u1);
        checks++; if (u1 !== 0) begin errors++; $display("FAIL density_early_underrun got %0d want 0", u1); end
        measure(3842, l2, r2, u2);
        checks++;
        if (l1 + l2 < ones_lo(e.l, 4096) || l1 + l2 > ones_hi(e.l, 4096)) begin
            errors++; $display("FAIL density_l ones=%0d want %0d", l1 + l2, ones_lo(e.l, 4096));
        end
        checks++;
        if (r1 + r2 < ones_lo(e.r, 4096) || r1 + r2 > ones_hi(e.r, 4096)) begin
            errors++; $display("FAIL density_r ones=%0d want %0d", r1 + r2, ones_lo(e.r, 4096));
        end
        checks++; if (u2 !== 16) begin errors++; $display("FAIL density_held_underruns got %0d want 16", u2); end
    endtask

    task automatic test_extremes();
        pair_t e;
        int l, r, u;
        do_reset();
        push_pair(16'h7FFF, 16'h8000);
        wait_tick();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL extreme_tick_underrun got %b want 0", underrun); end
        pop_expected(e);
        @(negedge clk);
        measure(4096, l, r, u);
        checks++;
        if (l < ones_lo(e.l, 4096) || l > ones_hi(e.l, 4096)) begin
            errors++; $display("FAIL extreme_l ones=%0d want %0d..%0d", l, ones_lo(e.l, 4096), ones_hi(e.l, 4096));
        end
        checks++; if (r !== ones_lo(e.r, 4096)) begin errors++; $display("FAIL extreme_r ones=%0d want %0d", r, ones_lo(e.r, 4096)); end
    endtask

    task automatic test_back_to_back();
        pair_t e;
        int idx = 0, l1, r1, u1, l2, r2, u2;
        do_reset();
        @(negedge clk);
        bus.s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.s_data_l = bl[idx > 4 ? 4 : idx];
            bus.s_data_r = br[idx > 4 ? 4 : idx];
            if (bus.s_ready === 1'b1 && idx < 5) begin
                sb.push_back('{bl[idx], br[idx]});
                idx++;
            end
            @(negedge clk);
        end
        checks++; if (idx !== 4) begin errors++; $display("FAIL b2b_accepted got %0d want 4", idx); end
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b want 0", bus.s_ready); end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL b2b_full_level got %0d want 4", fifo_level); end
        wait_tick();
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL b2b_tick_ready got %b want 0", bus.s_ready); end
        pop_expected(e);
        @(negedge clk);
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL b2b_pop_level got %0d want 3", fifo_level); end
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL b2b_pop_ready got %b want 1", bus.s_ready); end
        sb.push_back('{bl[4], br[4]});
        measure(1, l1, r1, u1);
        bus.s_valid = 1'b0;
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL b2b_refill_level got %0d want 4", fifo_level); end
        measure(255, l2, r2, u2);
        for (int p = 0; p < 5; p++) begin
            if (p > 0) begin
                pop_expected(e);
                measure(256, l2, r2, u2);
                l1 = 0; r1 = 0; u1 = 0;
            end
            checks++;
            if (l1 + l2 < ones_lo(e.l, 256) || l1 + l2 > ones_hi(e.l, 256)) begin
                errors++; $display("FAIL b2b_order_l pair=%0d ones=%0d want %0d", p, l1 + l2, ones_lo(e.l, 256));
            end
            checks++;
            if (r1 + r2 < ones_lo(e.r, 256) || r1 + r2 > ones_hi(e.r, 256)) begin
                errors++; $display("FAIL b2b_order_r pair=%0d ones=%0d want %0d", p, r1 + r2, ones_lo(e.r, 256));
            end
            checks++;
            if (u1 + u2 !== (sb.size() == 0 ? 1 : 0)) begin
                errors++; $display("FAIL b2b_underrun pair=%0d got %0d want %0d", p, u1 + u2, sb.size() == 0 ? 1 : 0);
            end
        end
    endtask

    task automatic test_push_on_tick();
        pair_t e;
        int l, r, u;
        do_reset();
        @(negedge clk);
        wait_tick();
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL tickpush_underrun got %b want 1", underrun); end
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL tickpush_ready got %b want 1", bus.s_ready); end
        bus.s_valid = 1'b1;
        bus.s_data_l = 16'hC000;
        bus.s_data_r = 16'h4000;
        sb.push_back('{16'hC000, 16'h4000});
        @(negedge clk);
        bus.s_valid = 1'b0;
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL tickpush_level got %0d want 1", fifo_level); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL tickpush_pulse_width got %b want 0", underrun); end
        measure(256, l, r, u);
        checks++; if (l !== ones_lo(16'h0000, 256)) begin errors++; $display("FAIL tickpush_held_l ones=%0d want %0d", l, ones_lo(16'h0000, 256)); end
        checks++; if (r !== ones_lo(16'h0000, 256)) begin errors++; $display("FAIL tickpush_held_r ones=%0d want %0d", r, ones_lo(16'h0000, 256)); end
        checks++; if (u !== 0) begin errors++; $display("FAIL tickpush_next_underrun got %0d want 0", u); end
        pop_expected(e);
        measure(256, l, r, u);
        checks++; if (l !== ones_lo(e.l, 256)) begin errors++; $display("FAIL tickpush_load_l ones=%0d want %0d", l, ones_lo(e.l, 256)); end
        checks++; if (r !== ones_lo(e.r, 256)) begin errors++; $display("FAIL tickpush_load_r ones=%0d want %0d", r, ones_lo(e.r, 256)); end
        checks++; if (u !== 1) begin errors++; $display("FAIL tickpush_drain_underrun got %0d want 1", u); end
    endtask

    task automatic test_reset_mid();
        logic e;
        do_reset();
        push_pair(16'h4000, 16'hA000);
        push_pair(16'h0000, 16'h2000);
        push_pair(16'hC000, 16'hE000);
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL midreset_pre_level got %0d want 3", fifo_level); end
        for (int i = 0; i < 4 && audio_l !== 1'b1; i++) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checks++; if (audio_l !== 1'b0) begin errors++; $display("FAIL midreset_audio_l got %b want 0", audio_l); end
        checks++; if (audio_r !== 1'b0) begin errors++; $display("FAIL midreset_audio_r got %b want 0", audio_r); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL midreset_level got %0d want 0", fifo_level); end
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got %b want 0", bus.s_ready); end
        sb.delete();
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            e = (cyc % 2 == 0);
            checks++; if (audio_l !== e) begin errors++; $display("FAIL midreset_pattern_l cyc=%0d got %b want %b", cyc, audio_l, e); end
            checks++; if (audio_r !== e) begin errors++; $display("FAIL midreset_pattern_r cyc=%0d got %b want %b", cyc, audio_r, e); end
        end
        wait_tick();
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL midreset_discarded got %b want 1", underrun); end
    endtask

    initial begin
        test_reset();
        test_midscale();
        test_density();
        test_extremes();
        test_back_to_back();
        test_push_on_tick();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t limit=2000000", $time);
        $fatal(1);
    end
endmodule
